systolic_result_drain: RTL and testbench
========================================

Name: systolic_result_drain

Overview:
- Sits on the output side of systolic_core and consumes its de-skewed, column-aligned result rows (N partial sums per cycle, all valid bits aligned).
- Requantizes each ACC_WIDTH sum to OUT_WIDTH with rounding shift, optional ReLU and saturation.
- Buffers quantized rows in a small row FIFO and serializes them one element per handshake onto a valid/ready stream.
- Provides tile framing (out_last) and sticky error flags, because the array cannot be stalled.

Parameters:
- N, 8, array width (elements per row).
- ACC_WIDTH, 32, signed partial-sum width from the array.
- OUT_WIDTH, 8, signed output element width.
- FIFO_DEPTH, 4, row FIFO depth in rows (power of two, ≥2).
- ROW_CNT_W, 16, width of the tile row counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a tile; sampled in IDLE only.
- tile_rows  in  ROW_CNT_W  rows in the tile; latched on start.
- cfg_shift  in  5  arithmetic right-shift amount; latched on start.
- cfg_relu  in  1  clamp negatives to 0; latched on start.
- y_in  in  N*ACC_WIDTH  aligned result row; column j at [j*ACC_WIDTH +: ACC_WIDTH].
- valid_in  in  N  per-column valid from the core.
- out_data  out  OUT_WIDTH  serialized quantized element.
- out_col  out  $clog2(N)  column index of out_data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  last element of the tile (column N-1 of the row tagged last).
- busy  out  1  high in ACTIVE or FLUSH.
- overflow  out  1  sticky: a row arrived while the FIFO was full.
- misalign  out  1  sticky: valid_in was neither all-zeros nor all-ones.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; counters 0; latched configuration cleared. Reset mid-tile discards everything, including buffered rows and sticky flags.
- Interface: clock is clk; reset is synchronous, active-high, named rst.
- FSM IDLE:
  - start with tile_rows≠0 latches the configuration, clears cap_cnt, and moves to ACTIVE.
  - start with tile_rows=0 is ignored.
  - Rows arriving in IDLE are ignored, but a partial valid_in still sets misalign.
- FSM ACTIVE:
  - A row is captured when valid_in is all-ones.
  - Every captured row increments cap_cnt, whether it is stored or dropped.
  - The row with cap_cnt = tile_rows-1 is tagged last; after capturing it, move to FLUSH.
- FSM FLUSH: further rows are ignored. When the FIFO is empty and the serializer is idle, return to IDLE. start is ignored while busy.
- Quantize, per column (stage 1, registered):
  - r = (y >>> s) + (s>0 ? y[s-1] : 0), computed at ACC_WIDTH+1 bits (round half up).
  - If cfg_relu and r<0, then r = 0.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- FIFO write: one cycle after capture. The entry is N*OUT_WIDTH data plus a last bit.
- Full is evaluated on the registered count, but a write is still allowed if a pop occurs in the same cycle.
- On a write when the FIFO is full and not popping: the row is dropped and overflow is set. If the dropped row was tagged last, no out_last occurs for the tile.
- Serializer:
  - Loads the head row when idle and the FIFO is non-empty.
  - Emits columns 0..N-1; out_col advances only on out_valid&&out_ready.
  - After column N-1 is accepted, it either pops the next row immediately (no bubble) or goes idle.
  - out_data, out_col and out_last stay stable while out_valid&&!out_ready.
- Latency: full row on valid_in at edge t → out_valid at edge t+2 (FIFO empty, serializer idle).
- Sustained throughput: one row per N cycles. Faster row arrival fills the FIFO, then overflows.
- Simultaneous events: the last-row capture and the FLUSH exit decision never occur in the same cycle.

Decomposition:
- Package systolic_pkg: OUT_WIDTH/ACC_WIDTH defaults, FSM state enum (IDLE, ACTIVE, FLUSH), and the saturate/round function.
- Sub-module row_fifo (parameterized width/depth, synchronous, count-based full/empty), instantiated once.

Test Plan:
- Test configuration: N=4, shift=4, relu=0, tile_rows=2. Rows {160, -24, 8, 4000} then {-5000, 0, 15, 7}.
  - Required stream: 10, -1, 1, 127, -128, 0, 1, 0.
  - out_last only on the 8th element; busy drops after it.
- Rounding: shift=1, y=3 → 2; y=-3 → -1.
- ReLU: relu=1 on row {-1, -200, 5, 0} with shift=0 → 0, 0, 5, 0.
- Backpressure: out_ready held low, 6 rows streamed with FIFO_DEPTH=4.
  - Rows 1..5 are held (4 in the FIFO plus 1 in the serializer); row 6 is dropped and overflow=1.
  - Releasing out_ready yields exactly 20 elements in order.
- Framing misuse: valid_in=4'b0110 → misalign=1, no capture. start while busy → no effect. tile_rows=0 → stays IDLE.
- Reset mid-tile: assert rst after 1 of 3 rows.
  - Next cycle: outputs 0, IDLE, flags clear.
  - A fresh 1-row tile then produces out_last on its 4th element.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and the requantization helper for the systolic result drain.
// The helper works at 64 bits so any ACC_WIDTH up to 62 rounds without overflow.
package systolic_pkg;

    localparam int ACC_WIDTH_DEF = 32;
    localparam int OUT_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH
    } drain_state_e;

    // Round-half-up arithmetic shift, optional ReLU, then saturation to ow bits.
    function automatic logic signed [63:0] requantize(
        input logic signed [63:0] y,
        input logic [4:0]         s,
        input logic               relu,
        input int                 ow
    );
        logic signed [63:0] t;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (s != 5'd0) begin
            t = y >>> (s - 5'd1);
            r = (t >>> 1) + (t & 64'sd1);
        end else begin
            t = y;
            r = y;
        end
        if (relu && (r < 64'sd0)) begin
            r = 64'sd0;
        end
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/row_fifo.sv
// Synchronous count-based FIFO holding whole quantized rows plus their last tag.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Drains aligned result rows from the systolic array: requantize, buffer, serialize.
// The array cannot be stalled, so lost rows and ragged valids are only flagged.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int N          = 8,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int ROW_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ROW_CNT_W-1:0]   tile_rows,
    input  logic [4:0]             cfg_shift,
    input  logic                   cfg_relu,
    input  logic [N*ACC_WIDTH-1:0] y_in,
    input  logic [N-1:0]           valid_in,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [$clog2(N)-1:0]   out_col,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   overflow,
    output logic                   misalign
);

    localparam int COL_W   = $clog2(N);
    localparam int ROW_W   = N * OUT_WIDTH;
    localparam int ENTRY_W = ROW_W + 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(N - 1);

    drain_state_e         state_q, state_d;
    logic [ROW_CNT_W-1:0] cap_cnt_q, cap_cnt_d;
    logic [ROW_CNT_W-1:0] tile_rows_q;
    logic [4:0]           shift_q;
    logic                 relu_q;
    logic                 cfg_load;
    logic                 capture;
    logic                 cap_last;
    logic                 row_full;
    logic                 row_partial;

    logic                 stg_valid_q;
    logic                 stg_last_q;
    logic [ROW_W-1:0]     stg_row_q;
    logic [ROW_W-1:0]     qrow;
    logic signed [ACC_WIDTH-1:0] ycol;
    logic signed [63:0]   qwide;

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   fifo_rd;

    logic                 ser_valid_q;
    logic                 ser_last_q;
    logic [COL_W-1:0]     ser_col_q;
    logic [ROW_W-1:0]     ser_row_q;
    logic                 overflow_q;
    logic                 misalign_q;

    assign row_full    = &valid_in;
    assign row_partial = (valid_in != '0) && !row_full;

    always_comb begin
        state_d   = state_q;
        cap_cnt_d = cap_cnt_q;
        cfg_load  = 1'b0;
        capture   = 1'b0;
        cap_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (tile_rows != '0)) begin
                    cfg_load  = 1'b1;
                    cap_cnt_d = '0;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (row_full) begin
                    capture   = 1'b1;
                    cap_last  = (cap_cnt_q == (tile_rows_q - ROW_CNT_W'(1)));
                    cap_cnt_d = cap_cnt_q + ROW_CNT_W'(1);
                    if (cap_last) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // The last row may still sit in the quantize stage, so include it.
                if (fifo_empty && !ser_valid_q && !stg_valid_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cap_cnt_q   <= '0;
            tile_rows_q <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cap_cnt_q <= cap_cnt_d;
            if (cfg_load) begin
                tile_rows_q <= tile_rows;
                shift_q     <= cfg_shift;
                relu_q      <= cfg_relu;
            end
        end
    end

    always_comb begin
        qrow  = '0;
        ycol  = '0;
        qwide = '0;
        for (int j = 0; j < N; j++) begin
            ycol  = y_in[j*ACC_WIDTH +: ACC_WIDTH];
            qwide = requantize({{(64-ACC_WIDTH){ycol[ACC_WIDTH-1]}}, ycol},
                               shift_q, relu_q, OUT_WIDTH);
            qrow[j*OUT_WIDTH +: OUT_WIDTH] = qwide[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q <= 1'b0;
            stg_last_q  <= 1'b0;
            stg_row_q   <= '0;
        end else begin
            stg_valid_q <= capture;
            stg_last_q  <= cap_last;
            if (capture) begin
                stg_row_q <= qrow;
            end
        end
    end

    assign fifo_pop = !fifo_empty &&
                      (!ser_valid_q || (out_ready && (ser_col_q == LAST_COL)));

    row_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (stg_valid_q),
        .pop_i     (fifo_pop),
        .wr_data_i ({stg_last_q, stg_row_q}),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Reloading on the final accepted column keeps back-to-back rows bubble-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            ser_col_q   <= '0;
            ser_row_q   <= '0;
        end else if (fifo_pop) begin
            ser_valid_q <= 1'b1;
            ser_last_q  <= fifo_rd[ENTRY_W-1];
            ser_row_q   <= fifo_rd[ROW_W-1:0];
            ser_col_q   <= '0;
        end else if (ser_valid_q && out_ready) begin
            if (ser_col_q == LAST_COL) begin
                ser_valid_q <= 1'b0;
                ser_col_q   <= '0;
            end else begin
                ser_col_q <= ser_col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (stg_valid_q && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
            if (row_partial) begin
                misalign_q <= 1'b1;
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < N; j++) begin
            if (ser_col_q == COL_W'(j)) begin
                out_data = ser_row_q[j*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign out_col   = ser_col_q;
    assign out_valid = ser_valid_q;
    assign out_last  = ser_valid_q && ser_last_q && (ser_col_q == LAST_COL);
    assign busy      = (state_q != IDLE);
    assign overflow  = overflow_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain with N=4, 32-bit sums, 8-bit outputs.
// A negedge monitor records every accepted element for in-order comparison.
module tb_systolic_result_drain;

    localparam int N   = 4;
    localparam int ACC = 32;
    localparam int OW  = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [15:0]    tile_rows;
    logic [4:0]     cfg_shift;
    logic           cfg_relu;
    logic [N*ACC-1:0] y_in;
    logic [N-1:0]   valid_in;
    logic [OW-1:0]  out_data;
    logic [1:0]     out_col;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic           busy;
    logic           overflow;
    logic           misalign;

    int compareCount  = 0;
    int mismatchCount = 0;
    int dataQ[$];
    int colQ[$];
    int lastQ[$];
    int expv[$];

    systolic_result_drain #(
        .N          (N),
        .ACC_WIDTH  (ACC),
        .OUT_WIDTH  (OW),
        .FIFO_DEPTH (4),
        .ROW_CNT_W  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tile_rows (tile_rows),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .y_in      (y_in),
        .valid_in  (valid_in),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow),
        .misalign  (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs only change 1ns after posedge, so negedge sees the upcoming handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            dataQ.push_back(int'($signed(out_data)));
            colQ.push_back(int'(out_col));
            lastQ.push_back(int'(out_last));
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearQueues();
        dataQ.delete();
        colQ.delete();
        lastQ.delete();
    endtask

    task automatic startTile(input int rows, input int shift, input bit relu);
        tile_rows = 16'(rows);
        cfg_shift = 5'(shift);
        cfg_relu  = relu;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input int v0, input int v1, input int v2, input int v3,
                                 input logic [N-1:0] vld);
        y_in[0*ACC +: ACC] = v0;
        y_in[1*ACC +: ACC] = v1;
        y_in[2*ACC +: ACC] = v2;
        y_in[3*ACC +: ACC] = v3;
        valid_in = vld;
        @(posedge clk);
        #1;
        valid_in = '0;
    endtask

    task automatic waitElements(input int n, input int budget);
        int cycles = 0;
        while (dataQ.size() < n && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (dataQ.size() < n) begin
            checkOutput("timeout_elements", dataQ.size(), n);
        end
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int cycles = 0;
        while (busy && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput(tag, int'(busy), 0);
    endtask

    task automatic checkStream(input string tag, input int expData[$], input int lastIdx);
        checkOutput($sformatf("%s_count", tag), dataQ.size(), expData.size());
        for (int i = 0; i < expData.size(); i++) begin
            if (i < dataQ.size()) begin
                checkOutput($sformatf("%s_data%0d", tag, i), dataQ[i], expData[i]);
                checkOutput($sformatf("%s_col%0d", tag, i), colQ[i], i % N);
                checkOutput($sformatf("%s_last%0d", tag, i), lastQ[i], (i == lastIdx) ? 1 : 0);
            end
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_data"}, int'(out_data), 0);
        checkOutput({tag, "_col"}, int'(out_col), 0);
        checkOutput({tag, "_last"}, int'(out_last), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_overflow"}, int'(overflow), 0);
        checkOutput({tag, "_misalign"}, int'(misalign), 0);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        tile_rows = '0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        y_in      = '0;
        valid_in  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkQuiet("reset");
        rst = 1'b0;

        // Two-row tile with shift 4: rounding plus saturation on both rails.
        $display("[TB] basic two-row tile");
        clearQueues();
        startTile(2, 4, 1'b0);
        checkOutput("basic_busy", int'(busy), 1);
        applyStimulus(160, -24, 8, 4000, 4'b1111);
        applyStimulus(-5000, 0, 15, 7, 4'b1111);
        waitElements(8, 100);
        expv = '{10, -1, 1, 127, -128, 0, 1, 0};
        checkStream("basic", expv, 7);
        waitIdle("basic_idle", 10);

        // Round half up on both signs, and the two-cycle fill latency.
        $display("[TB] rounding and latency");
        clearQueues();
        startTile(1, 1, 1'b0);
        applyStimulus(3, -3, 0, 1, 4'b1111);
        checkOutput("lat_t0", int'(out_valid), 0);
        @(posedge clk);
        #1;
        checkOutput("lat_t1", int'(out_valid), 0);
        @(posedge clk);
        #1;
        checkOutput("lat_t2", int'(out_valid), 1);
        waitElements(4, 50);
        expv = '{2, -1, 0, 1};
        checkStream("round", expv, 3);
        waitIdle("round_idle", 10);

        $display("[TB] relu");
        clearQueues();
        startTile(1, 0, 1'b1);
        applyStimulus(-1, -200, 5, 0, 4'b1111);
        waitElements(4, 50);
        expv = '{0, 0, 5, 0};
        checkStream("relu", expv, 3);
        waitIdle("relu_idle", 10);

        // Six back-to-back rows against a stalled sink: five held, sixth dropped.
        $display("[TB] backpressure");
        clearQueues();
        out_ready = 1'b0;
        startTile(6, 0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(k*10, k*10+1, k*10+2, k*10+3, 4'b1111);
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_overflow", int'(overflow), 1);
        checkOutput("bp_valid", int'(out_valid), 1);
        checkOutput("bp_hold_data", int'($signed(out_data)), 10);
        checkOutput("bp_hold_col", int'(out_col), 0);
        checkOutput("bp_none_taken", dataQ.size(), 0);
        out_ready = 1'b1;
        waitElements(20, 100);
        waitIdle("bp_idle", 20);
        repeat (10) @(posedge clk);
        #1;
        expv.delete();
        for (int k = 1; k <= 5; k++) begin
            for (int c = 0; c < N; c++) begin
                expv.push_back(k*10 + c);
            end
        end
        checkStream("bp", expv, -1);

        $display("[TB] framing misuse");
        pulseReset();
        checkOutput("misuse_ovf_cleared", int'(overflow), 0);
        clearQueues();
        applyStimulus(1, 2, 3, 4, 4'b0110);
        checkOutput("misuse_misalign_idle", int'(misalign), 1);
        checkOutput("misuse_idle_busy", int'(busy), 0);
        startTile(1, 0, 1'b0);
        applyStimulus(5, 6, 7, 8, 4'b0110);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("misuse_no_capture", dataQ.size(), 0);
        checkOutput("misuse_still_busy", int'(busy), 1);
        startTile(5, 3, 1'b1);
        applyStimulus(7, 8, 9, 10, 4'b1111);
        waitElements(4, 50);
        expv = '{7, 8, 9, 10};
        checkStream("misuse", expv, 3);
        waitIdle("misuse_start_ignored", 10);
        startTile(0, 0, 1'b0);
        checkOutput("zero_rows_idle", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("zero_rows_idle_later", int'(busy), 0);

        // Reset with one row in flight must discard it and the sticky flag.
        $display("[TB] reset mid-tile");
        clearQueues();
        startTile(3, 0, 1'b0);
        applyStimulus(1, 1, 1, 1, 4'b0011);
        applyStimulus(100, 101, 102, 103, 4'b1111);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkQuiet("midreset");
        rst = 1'b0;
        startTile(1, 0, 1'b0);
        applyStimulus(1, 2, 3, 4, 4'b1111);
        waitElements(4, 50);
        repeat (10) @(posedge clk);
        #1;
        expv = '{1, 2, 3, 4};
        checkStream("fresh", expv, 3);
        checkOutput("fresh_idle", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
